// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_core slice: opcodes, condition codes, FSM
// states, instruction field positions and the flag record.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LD  = 4'd1;
    localparam logic [3:0] OP_STR = 4'd2;
    localparam logic [3:0] OP_BRA = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_ADD = 4'd5;
    localparam logic [3:0] OP_ROT = 4'd6;
    localparam logic [3:0] OP_SHF = 4'd7;
    localparam logic [3:0] OP_HLT = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    localparam logic [2:0] CC_ALW = 3'd0;
    localparam logic [2:0] CC_PAR = 3'd1;
    localparam logic [2:0] CC_EVN = 3'd2;
    localparam logic [2:0] CC_CAR = 3'd3;
    localparam logic [2:0] CC_NEG = 3'd4;
    localparam logic [2:0] CC_ZRO = 3'd5;
    localparam logic [2:0] CC_NCA = 3'd6;
    localparam logic [2:0] CC_POS = 3'd7;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 28;
    localparam int TYPE_BIT = 27;
    localparam int CC_HI    = 26;
    localparam int CC_LO    = 24;
    localparam int SRC_HI   = 23;
    localparam int SRC_LO   = 12;
    localparam int DST_HI   = 11;
    localparam int DST_LO   = 0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    // Packed so that the record reads {C,P,E,N,Z} as a 5-bit vector.
    typedef struct packed {
        logic c;
        logic p;
        logic e;
        logic n;
        logic z;
    } flags_t;

    function automatic logic cc_true(input logic [2:0] cc, input flags_t f);
        logic t;
        case (cc)
            CC_ALW:  t = 1'b1;
            CC_PAR:  t = f.p;
            CC_EVN:  t = f.e;
            CC_CAR:  t = f.c;
            CC_NEG:  t = f.n;
            CC_ZRO:  t = f.z;
            CC_NCA:  t = ~f.c;
            default: t = ~f.n;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational datapath of cpu_core: load pass-through, xor, add, complement,
// logical shift, rotate, and the C/P/E/N/Z flags of the result.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [11:0] cnt_i,
    output logic [31:0] result_o,
    output flags_t      flags_o
);

    logic        carry;
    logic [63:0] sh64;
    logic [11:0] mag;
    logic        neg;
    logic [4:0]  rot;

    always_comb begin
        result_o = a_i;
        carry    = 1'b0;
        sh64     = '0;
        neg      = cnt_i[11];
        mag      = -cnt_i;
        rot      = neg ? mag[4:0] : cnt_i[4:0];
        case (op_i)
            OP_LD:  result_o = b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_ADD: {carry, result_o} = {1'b0, a_i} + {1'b0, b_i};
            OP_CMP: result_o = ~b_i;
            OP_SHF: begin
                // The spare 32 bits catch the last bit shifted out as the carry.
                if (!neg) begin
                    sh64     = {a_i, 32'b0} >> cnt_i;
                    result_o = sh64[63:32];
                    carry    = sh64[31];
                end else begin
                    sh64     = {32'b0, a_i} << mag;
                    result_o = sh64[31:0];
                    carry    = sh64[32];
                end
            end
            OP_ROT: begin
                if (!neg) begin
                    result_o = (a_i >> rot) | (a_i << (6'd32 - {1'b0, rot}));
                    carry    = (rot != 5'd0) & result_o[31];
                end else begin
                    result_o = (a_i << rot) | (a_i >> (6'd32 - {1'b0, rot}));
                    carry    = (rot != 5'd0) & result_o[0];
                end
            end
            default: result_o = a_i;
        endcase
        flags_o.c = carry;
        flags_o.p = ^result_o;
        flags_o.e = ~result_o[0];
        flags_o.n = result_o[31];
        flags_o.z = (result_o == 32'd0);
    end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle 32-bit core (FETCH/EXEC/MEM/HALT) with a 16-entry register file.
// Optional debug ports guarded by CPU_DEBUG_EN.
module cpu_core
    import cpu_pkg::*;
#(
    parameter logic [11:0] RESET_PC = 12'd0,
    parameter int          NREG     = 16
) (
    input  logic        clock,
    input  logic        reset,
    output logic [11:0] address,
    input  logic [31:0] in_data,
    output logic [31:0] out_data,
    output logic        write,
    output logic        halted
`ifdef CPU_DEBUG_EN
    ,
    input  logic [3:0]  reg_sel,
    output logic [31:0] reg_dbg,
    output logic [4:0]  psr
`endif
);

    state_e      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    flags_t      flags_q, flags_d;
    logic [31:0] regs_q [NREG];

    logic [3:0]  opc;
    logic        imm;
    logic [2:0]  cc;
    logic [11:0] src;
    logic [11:0] dst;
    logic [31:0] rf_src;
    logic [31:0] rf_dst;
    logic [31:0] operand;
    logic [31:0] alu_result;
    flags_t      alu_flags;
    logic        rf_we;

    assign opc    = ir_q[OPC_HI:OPC_LO];
    assign imm    = ir_q[TYPE_BIT];
    assign cc     = ir_q[CC_HI:CC_LO];
    assign src    = ir_q[SRC_HI:SRC_LO];
    assign dst    = ir_q[DST_HI:DST_LO];
    assign rf_src = regs_q[src[3:0]];
    assign rf_dst = regs_q[dst[3:0]];

    // In MEM only a register-indirect LD consumes the operand, taken from memory.
    assign operand = (state_q == ST_MEM) ? in_data : (imm ? {20'd0, src} : rf_src);

    cpu_alu u_alu (
        .op_i     (opc),
        .a_i      (rf_dst),
        .b_i      (operand),
        .cnt_i    (src),
        .result_o (alu_result),
        .flags_o  (alu_flags)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        flags_d  = flags_q;
        rf_we    = 1'b0;
        address  = pc_q;
        write    = 1'b0;
        out_data = 32'd0;
        case (state_q)
            ST_FETCH: begin
                ir_d    = in_data;
                pc_d    = pc_q + 12'd1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (opc)
                    OP_LD: begin
                        if (imm) begin
                            rf_we   = 1'b1;
                            flags_d = alu_flags;
                        end else begin
                            state_d = ST_MEM;
                        end
                    end
                    OP_STR: state_d = ST_MEM;
                    OP_BRA: begin
                        if (cc_true(cc, flags_q)) pc_d = rf_dst[11:0];
                    end
                    OP_HLT: state_d = ST_HALT;
                    OP_XOR, OP_ADD, OP_CMP, OP_SHF, OP_ROT: begin
                        rf_we   = 1'b1;
                        flags_d = alu_flags;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                state_d = ST_FETCH;
                if (opc == OP_STR) begin
                    address  = rf_dst[11:0];
                    write    = 1'b1;
                    out_data = imm ? {20'd0, src} : rf_src;
                end else begin
                    address = rf_src[11:0];
                    rf_we   = 1'b1;
                    flags_d = alu_flags;
                end
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    // write is decoded from state, so an asynchronous reset drops it at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= 32'd0;
        end else if (rf_we) begin
            regs_q[dst[3:0]] <= alu_result;
        end
    end

    assign halted = (state_q == ST_HALT);

`ifdef CPU_DEBUG_EN
    assign reg_dbg = regs_q[reg_sel];
    assign psr     = flags_q;
`endif

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: two instances (RESET_PC 0 and 4061) each with a
// word memory model; stores are checked against an expected queue.
module tb_cpu_core;

    localparam logic [3:0] LD  = 4'd1;
    localparam logic [3:0] STR = 4'd2;
    localparam logic [3:0] BRA = 4'd3;
    localparam logic [3:0] ADD = 4'd5;
    localparam logic [3:0] SHF = 4'd7;
    localparam logic [3:0] HLT = 4'd8;
    localparam logic [3:0] CMP = 4'd9;
    localparam logic [2:0] ALW = 3'd0;
    localparam logic [2:0] CAR = 3'd3;
    localparam logic [2:0] NEG = 3'd4;
    localparam logic [2:0] ZRO = 3'd5;
    localparam logic [2:0] NCA = 3'd6;
    localparam logic [2:0] POS = 3'd7;

    logic        clk = 1'b0;
    logic        rst0, rst1;
    logic [11:0] addr0, addr1;
    logic [31:0] din0, din1, dout0, dout1;
    logic        w0, w1, h0, h1;
    logic [31:0] mem0 [4096];
    logic [31:0] mem1 [4096];
    logic [43:0] exp_q [$];
    logic        prev_w0 = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    cpu_core #(.RESET_PC(12'd0), .NREG(16)) dut0 (
        .clock(clk), .reset(rst0), .address(addr0), .in_data(din0),
        .out_data(dout0), .write(w0), .halted(h0)
    );

    cpu_core #(.RESET_PC(12'd4061), .NREG(16)) dut1 (
        .clock(clk), .reset(rst1), .address(addr1), .in_data(din1),
        .out_data(dout1), .write(w1), .halted(h1)
    );

    assign din0 = mem0[addr0];
    assign din1 = mem1[addr1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] op, input logic t, input logic [2:0] cc,
                                        input logic [11:0] src, input logic [11:0] dst);
        return {op, t, cc, src, dst};
    endfunction

    // Memory model for dut0 plus the store scoreboard.
    always @(negedge clk) begin
        logic [43:0] e;
        if (w0) begin
            check("wr_one_cycle", {31'd0, prev_w0}, 32'd0);
            if (exp_q.size() == 0) begin
                check("wr_extra_addr", {20'd0, addr0}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {20'd0, addr0}, {20'd0, e[43:32]});
                check("wr_data", dout0, e[31:0]);
            end
            mem0[addr0] = dout0;
        end
        prev_w0 = w0;
    end

    always @(negedge clk) begin
        if (w1) mem1[addr1] = dout1;
    end

    initial begin
        logic found;
        for (int i = 0; i < 4096; i++) begin
            mem0[i] = 32'd0;
            mem1[i] = 32'd0;
        end
        // dut0 program
        mem0[0]   = enc(LD,  1'b1, ALW, 12'd200, 12'd9);
        mem0[1]   = enc(LD,  1'b1, ALW, 12'd30,  12'd10);
        mem0[2]   = enc(LD,  1'b1, ALW, 12'd40,  12'd11);
        mem0[3]   = enc(LD,  1'b1, ALW, 12'd100, 12'd15);
        mem0[4]   = enc(LD,  1'b1, ALW, 12'd5,   12'd0);
        mem0[5]   = enc(ADD, 1'b1, ALW, 12'd1,   12'd0);
        mem0[6]   = enc(BRA, 1'b0, ZRO, 12'd0,   12'd9);
        mem0[7]   = enc(BRA, 1'b0, NEG, 12'd0,   12'd9);
        mem0[8]   = enc(STR, 1'b0, ALW, 12'd0,   12'd15);
        mem0[9]   = enc(LD,  1'b1, ALW, 12'd1,   12'd6);
        mem0[10]  = enc(CMP, 1'b0, ALW, 12'd6,   12'd6);
        mem0[11]  = enc(ADD, 1'b1, ALW, 12'd1,   12'd6);
        mem0[12]  = enc(BRA, 1'b0, POS, 12'd0,   12'd9);
        mem0[13]  = enc(LD,  1'b1, ALW, 12'd101, 12'd14);
        mem0[14]  = enc(STR, 1'b0, ALW, 12'd6,   12'd14);
        mem0[15]  = enc(LD,  1'b1, ALW, 12'd11,  12'd2);
        mem0[16]  = enc(LD,  1'b1, ALW, 12'hA5,  12'd3);
        mem0[17]  = enc(STR, 1'b0, ALW, 12'd3,   12'd2);
        mem0[18]  = enc(LD,  1'b1, ALW, 12'd1,   12'd0);
        mem0[19]  = enc(SHF, 1'b1, ALW, 12'hFE1, 12'd0);
        mem0[20]  = enc(SHF, 1'b1, ALW, 12'hFFF, 12'd0);
        mem0[21]  = enc(BRA, 1'b0, NCA, 12'd0,   12'd9);
        mem0[22]  = enc(BRA, 1'b0, CAR, 12'd0,   12'd10);
        mem0[23]  = enc(HLT, 1'b0, ALW, 12'd0,   12'd0);
        mem0[30]  = enc(STR, 1'b0, ALW, 12'd0,   12'd14);
        mem0[31]  = enc(BRA, 1'b0, ZRO, 12'd0,   12'd11);
        mem0[32]  = enc(HLT, 1'b0, ALW, 12'd0,   12'd0);
        mem0[40]  = enc(STR, 1'b1, ALW, 12'h7E,  12'd15);
        mem0[41]  = enc(STR, 1'b1, ALW, 12'h55,  12'd2);
        mem0[42]  = enc(HLT, 1'b0, ALW, 12'd0,   12'd0);
        mem0[200] = enc(HLT, 1'b0, ALW, 12'd0,   12'd0);
        exp_q.push_back({12'd100, 32'd6});
        exp_q.push_back({12'd101, 32'hFFFF_FFFF});
        exp_q.push_back({12'd11,  32'hA5});
        exp_q.push_back({12'd101, 32'd0});
        exp_q.push_back({12'd100, 32'h7E});
        // dut1: swap-loop reversal of mem[0..11], then NOPs wrap through 0 to HLT at 12
        mem1[4061] = enc(LD,  1'b1, ALW, 12'd11,   12'd1);
        mem1[4062] = enc(CMP, 1'b1, ALW, 12'd0,    12'd13);
        mem1[4063] = enc(CMP, 1'b1, ALW, 12'd5,    12'd5);
        mem1[4064] = enc(LD,  1'b1, ALW, 12'd4065, 12'd6);
        mem1[4065] = enc(LD,  1'b0, ALW, 12'd0,    12'd2);
        mem1[4066] = enc(LD,  1'b0, ALW, 12'd1,    12'd3);
        mem1[4067] = enc(STR, 1'b0, ALW, 12'd3,    12'd0);
        mem1[4068] = enc(STR, 1'b0, ALW, 12'd2,    12'd1);
        mem1[4069] = enc(ADD, 1'b1, ALW, 12'd1,    12'd0);
        mem1[4070] = enc(ADD, 1'b0, ALW, 12'd13,   12'd1);
        mem1[4071] = enc(ADD, 1'b1, ALW, 12'd1,    12'd5);
        mem1[4072] = enc(BRA, 1'b0, NCA, 12'd0,    12'd6);
        for (int i = 0; i < 12; i++) mem1[i] = 32'(i + 1);
        mem1[12] = enc(HLT, 1'b0, ALW, 12'd0, 12'd0);

        // clock/reset
        rst0 = 1'b1;
        rst1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr0", {20'd0, addr0}, 32'd0);
        check("rst_write0", {31'd0, w0}, 32'd0);
        check("rst_halt0", {31'd0, h0}, 32'd0);
        check("rst_dout0", dout0, 32'd0);
        check("rst_addr1", {20'd0, addr1}, 32'd4061);
        @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Two cycles per non-memory instruction: address shows PC in both states.
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            check("fetch_trace", {20'd0, addr0}, 32'((n + 1) / 2));
        end

        // Reset asserted inside the MEM cycle of the final store must cancel it.
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(posedge clk);
            #1;
            if (w0 && addr0 == 12'd11 && dout0 == 32'h55) found = 1'b1;
        end
        check("mem_str_seen", {31'd0, found}, 32'd1);
        rst0 = 1'b1;
        #1;
        check("rst_mid_write", {31'd0, w0}, 32'd0);
        check("rst_mid_addr", {20'd0, addr0}, 32'd0);
        check("rst_mid_dout", dout0, 32'd0);
        @(negedge clk);
        #1;
        check("mem11_kept", mem0[11], 32'hA5);
        check("mem100", mem0[100], 32'h7E);
        check("mem101", mem0[101], 32'd0);
        check("wr_pending", 32'(exp_q.size()), 32'd0);

        // dut1 reversal result and halt behaviour.
        for (int i = 0; i < 3000 && !h1; i++) begin
            @(posedge clk);
            #1;
        end
        check("halt1", {31'd0, h1}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("halt1_pc", {20'd0, addr1}, 32'd13);
            check("halt1_hold", {31'd0, h1}, 32'd1);
            check("halt1_write", {31'd0, w1}, 32'd0);
        end
        for (int i = 0; i < 12; i++) check("rev_mem", mem1[i], 32'(12 - i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 SHALL provide parameter RESET_PC, default 12'd0: fetch address loaded on reset.
REQ-002 SHALL provide parameter NREG, default 16: register-file depth; register index is the low 4 bits of an operand field.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clock  input  1  system clock; all state changes on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 address  output  12  memory word address, for fetch, load and store.
REQ-007 in_data  input  32  memory read data, combinational from the memory's out_data.
REQ-008 out_data  output  32  store data, driven to the memory's in_data.
REQ-009 write  output  1  memory write strobe; the memory samples it on negedge clock.
REQ-010 halted  output  1  high once HLT has executed.

Function
REQ-011 Instruction format SHALL be: [31:28] opcode, [27] source type (1 = immediate), [26:24] cc, [23:12] src, [11:0] dst.
REQ-012 The FSM SHALL have states FETCH, EXEC, MEM and HALT.
- FETCH: address=PC; latch IR; PC+1, wrapping 4095->0.
- EXEC: execute; go to MEM for a register-indirect LD or any STR, else to FETCH.
- MEM: complete the memory access, then go to FETCH.
- Latency: 2 cycles for non-memory instructions, 3 cycles for memory instructions.
REQ-013 LD SHALL load R[dst] with zero-extended src when the source is immediate; otherwise it SHALL load R[dst] with mem[R[src][11:0]].
REQ-014 STR SHALL write mem[R[dst][11:0]] with R[src], or with zero-extended src when the source is immediate.
- write is high for exactly the one MEM cycle.
- address and out_data are stable throughout that cycle.
REQ-015 XOR and ADD SHALL compute R[dst] = R[dst] op operand.
- ADD carry is bit 32 of the 33-bit sum.
REQ-016 CMP SHALL compute R[dst] = ~operand (ones complement).
REQ-017 SHF and ROT shift count SHALL always be the src field as signed 12-bit; the type bit is ignored.
- Positive count shifts right; negative shifts left.
- SHF is logical; |count| >= 32 gives 0.
- ROT rotates by count mod 32.
- C = last bit shifted out; C = 0 for a zero count.
REQ-018 BRA SHALL set PC = R[dst][11:0] when cc is true, else do nothing.
REQ-019 Condition codes SHALL be: ALW=0 always; PAR=1 odd parity; EVN=2 result LSB 0; CAR=3 C; NEG=4 N; ZRO=5 Z; NCA=6 !C; POS=7 !N.
REQ-020 Flags C, P, E, N and Z SHALL be updated by LD, XOR, ADD, CMP, SHF and ROT.
- C is cleared by LD, XOR and CMP.
- NOP, STR, BRA and HLT leave all flags unchanged.
REQ-021 The operand SHALL be read before writeback, so dst==src uses the old value.
REQ-022 HLT SHALL enter HALT, assert halted and hold PC; only reset exits HALT.
REQ-023 Opcodes 1010-1111 SHALL execute as NOP.

Reset
REQ-024 Reset SHALL asynchronously force the following:
- state=FETCH, PC=RESET_PC, address=RESET_PC.
- write=0, out_data=0, halted=0.
- All flags 0 and all registers 0.
REQ-025 Reset asserted during a MEM-cycle STR SHALL drop write immediately, so no partial store occurs.

Configuration
REQ-026 With macro CPU_DEBUG_EN defined, the core SHALL add ports:
- reg_sel input 4: register select.
- reg_dbg output 32: combinational R[reg_sel].
- psr output 5: {C,P,E,N,Z}.
REQ-027 Without CPU_DEBUG_EN, those ports and their logic SHALL be absent, with identical behaviour otherwise.

Structure
REQ-028 Package cpu_pkg SHALL hold the opcode constants, the cc constants, the FSM state typedef and the instruction field positions.
REQ-029 Shift, rotate, add, xor, complement and flag generation SHALL be in combinational sub-module cpu_alu.

Verification
REQ-030 The bench SHALL cover the following scenarios:
- Reset with RESET_PC=0: address=0, write=0, halted=0; first IR latched from mem[0].
- LD #5->R0, ADD #1->R0: R0=6, N=0, Z=0, ADD completes in 2 cycles.
- LD #1->R6, CMP R6->R6, ADD #1->R6: R6=32'hFFFFFFFF, N=1; then BRA POS is not taken.
- R2=11, R3=32'hA5, STR R3->[R2]: write high one cycle, address=11, out_data=32'hA5; mem[11]=32'hA5.
- R0=32'h80000000, SHF #-1: R0=0, C=1, Z=1; then BRA NCA is not taken and BRA CAR is taken.
- Reverse-12 program at RESET_PC=4061, mem[0..11]=1..12: final mem[0..11]=12..1, halted=1, PC stable.
